// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_pkg
// Purpose  : Shared constants for the memory-stage responder.
//            - one-hot FSM state encodings (IDLE/REQ/DONE)
//            - default address/data widths
//            - default REQ timeout (in cycles)
// Ports    : none (package)
// Options  : MEM_STAGE_TIMEOUT_EN enables the REQ timeout in mem_stage_unit
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  // One-hot state encodings, kept as plain 3-bit constants so they match the
  // sequencer-side encoding used elsewhere in the core.
  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_REQ  = 3'b010;
  localparam logic [2:0] ST_DONE = 3'b100;

  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_TIMEOUT_CYC = 15;

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : mem_timeout_ctr
// Purpose  : Counts un-acknowledged REQ cycles and flags the last permitted
//            one, so the parent can abort on the edge that ends it.
// Ports    : clk           - clock, rising edge
//            rst_n         - asynchronous active-low reset
//            clear         - restart the count (REQ entry)
//            enable        - count this cycle (in REQ, no ack)
//            limit_reached - this is the LIMIT-th un-acked REQ cycle
// Options  : instantiated only when MEM_STAGE_TIMEOUT_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
module mem_timeout_ctr
  import mem_stage_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic limit_reached
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  // count holds the number of un-acked REQ cycles already completed. When it
  // equals LIMIT-1 the current cycle is the LIMIT-th, and the count would
  // reach LIMIT on the coming edge: that is the abort point.
  assign limit_reached = (count == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !limit_reached) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule : mem_timeout_ctr
`default_nettype wire

// File: rtl/mem_stage_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_unit
// Purpose  : Memory-stage responder. Takes the one-hot memory enable pulse
//            from the stage sequencer, performs one load/store over a req/ack
//            handshake and reports completion, stall and load data back.
// Ports    : I_clk, I_reset_n          - clock / async active-low reset
//            I_enmem, I_we, I_addr,
//            I_wdata                   - access request from the sequencer
//            O_stall, O_done, O_err,
//            O_rdata                   - status and load data to datapath
//            O_mreq, O_mwe, O_maddr,
//            O_mwdata, I_mack, I_mrdata - external data memory handshake
// Options  : MEM_STAGE_TIMEOUT_EN - abort REQ after TIMEOUT_CYC un-acked
//            cycles and flag O_err with O_done. Undefined: wait forever,
//            O_err tied low.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_unit
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              I_clk,
  input  logic              I_reset_n,
  input  logic              I_enmem,
  input  logic              I_we,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic [DATA_W-1:0] I_wdata,
  output logic              O_stall,
  output logic              O_done,
  output logic              O_err,
  output logic [DATA_W-1:0] O_rdata,
  output logic              O_mreq,
  output logic              O_mwe,
  output logic [ADDR_W-1:0] O_maddr,
  output logic [DATA_W-1:0] O_mwdata,
  input  logic              I_mack,
  input  logic [DATA_W-1:0] I_mrdata
);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              in_idle;
  logic              in_req;
  logic              in_done;
  logic              accept;
  logic              timeout_hit;

  assign in_idle = (state == ST_IDLE);
  assign in_req  = (state == ST_REQ);
  assign in_done = (state == ST_DONE);

  // Enable pulses outside IDLE are dropped: no queueing.
  assign accept = in_idle & I_enmem;

`ifdef MEM_STAGE_TIMEOUT_EN
  logic limit_reached;
  logic err_q;

  mem_timeout_ctr #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timeout_ctr (
    .clk          (I_clk),
    .rst_n        (I_reset_n),
    .clear        (accept),
    .enable       (in_req & ~I_mack),
    .limit_reached(limit_reached)
  );

  // An ack on the limit cycle wins over the abort.
  assign timeout_hit = in_req & ~I_mack & limit_reached;

  // Registered so it lines up with the DONE cycle; self-clears after it.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_hit;
    end
  end

  assign O_err = err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign timeout_hit        = 1'b0;
  assign O_err              = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (I_enmem)                state_nxt = ST_REQ;
      ST_REQ:  if (I_mack || timeout_hit)  state_nxt = ST_DONE;
      ST_DONE:                             state_nxt = ST_IDLE;
      default:                             state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= I_we;
        addr_q  <= I_addr;
        wdata_q <= I_wdata;
      end
      // Only an acknowledged load updates the returned data.
      if (in_req && I_mack && !we_q) begin
        rdata_q <= I_mrdata;
      end
    end
  end

  // Handshake outputs decode straight from state so an async reset drops
  // O_mreq immediately. Address/data/we hold after completion; O_mreq alone
  // qualifies them.
  assign O_mreq   = in_req;
  assign O_stall  = in_req;
  assign O_done   = in_done;
  assign O_mwe    = we_q;
  assign O_maddr  = addr_q;
  assign O_mwdata = wdata_q;
  assign O_rdata  = rdata_q;

endmodule : mem_stage_unit
`default_nettype wire

// File: tb/tb_mem_stage_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_unit
// Purpose  : Self-checking bench for mem_stage_unit: reset values, a table of
//            directed accesses, re-entry / mid-access reset sequences, random
//            accesses against a transaction-level model, and (when
//            MEM_STAGE_TIMEOUT_EN is defined) timeout and ack-on-limit cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enmem;
  logic        tb_we;
  logic [15:0] tb_addr;
  logic [15:0] tb_wdata;
  logic        stall;
  logic        done;
  logic        err;
  logic [15:0] rdata;
  logic        mreq;
  logic        mwe;
  logic [15:0] maddr;
  logic [15:0] mwdata;
  logic        mack;
  logic [15:0] mrdata;

  int tests = 0;
  int fails = 0;
  logic [15:0] model_rdata;

  always #5 clk = ~clk;

  mem_stage_unit #(
    .ADDR_W     (16),
    .DATA_W     (16),
    .TIMEOUT_CYC(TO)
  ) dut (
    .I_clk    (clk),
    .I_reset_n(rst_n),
    .I_enmem  (enmem),
    .I_we     (tb_we),
    .I_addr   (tb_addr),
    .I_wdata  (tb_wdata),
    .O_stall  (stall),
    .O_done   (done),
    .O_err    (err),
    .O_rdata  (rdata),
    .O_mreq   (mreq),
    .O_mwe    (mwe),
    .O_maddr  (maddr),
    .O_mwdata (mwdata),
    .I_mack   (mack),
    .I_mrdata (mrdata)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          waits;
    logic [15:0] mrdata;
    logic [15:0] exp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // waits < 0 means the memory never acknowledges.
  function automatic bit timed_out(input int waits);
`ifdef MEM_STAGE_TIMEOUT_EN
    return (waits < 0) || (waits >= TO);
`else
    return (waits < -1000000);
`endif
  endfunction

  // Drives one access starting in the current (post-edge) slot with the DUT
  // idle, then observes it cycle by cycle. Cycle i is the cycle after edge
  // i-1, where edge 0 samples the enable pulse.
  task automatic run_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                            input int waits, input logic [15:0] mem_data,
                            input logic [15:0] exp_rdata, input bit pulse_again,
                            input string name);
    int req_len, stall_cnt, done_cnt, err_cnt, first_done, mreq_bad, hold_bad;
    bit exp_err;
    exp_err = timed_out(waits);
    req_len = exp_err ? TO : waits + 1;
    stall_cnt = 0; done_cnt = 0; err_cnt = 0; first_done = -1; mreq_bad = 0; hold_bad = 0;

    enmem    = 1'b1;
    tb_we    = we;
    tb_addr  = addr;
    tb_wdata = wdata;
    mack     = 1'($urandom_range(0, 1));  // ack while idle must be ignored
    mrdata   = 16'($urandom);

    for (int i = 1; i <= req_len + 3; i++) begin
      @(posedge clk); #1;
      enmem    = pulse_again && (i == 2 || i == req_len + 1);
      tb_we    = ~we;
      tb_addr  = 16'($urandom);
      tb_wdata = 16'($urandom);
      mack     = (waits >= 0) && (i == waits + 1);
      mrdata   = mack ? mem_data : 16'($urandom);
      if (stall) stall_cnt++;
      if (mreq !== stall) mreq_bad++;
      if (mreq && (maddr !== addr || mwdata !== wdata || mwe !== we)) hold_bad++;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = i;
        if (err) err_cnt++;
      end else if (err) begin
        err_cnt += 100;
      end
    end
    enmem = 1'b0;
    mack  = 1'b0;

    check({name, ".stall_cycles"}, stall_cnt, req_len);
    check({name, ".done_cycle"}, first_done, req_len + 1);
    check({name, ".done_count"}, done_cnt, 1);
    check({name, ".err"}, err_cnt, {31'd0, exp_err});
    check({name, ".mreq_vs_stall"}, mreq_bad, 0);
    check({name, ".req_stable"}, hold_bad, 0);
    check({name, ".maddr_hold"}, maddr, addr);
    check({name, ".mwe_hold"}, mwe, we);
    check({name, ".rdata"}, rdata, exp_rdata);
  endtask

  initial begin
    vec_t vecs[5];
    int   done_seen;
    vecs[0] = '{we: 1'b0, addr: 16'h0040, wdata: 16'h0000, waits: 0, mrdata: 16'hBEEF, exp_rdata: 16'hBEEF};
    vecs[1] = '{we: 1'b1, addr: 16'h1234, wdata: 16'h5A5A, waits: 3, mrdata: 16'hDEAD, exp_rdata: 16'hBEEF};
    vecs[2] = '{we: 1'b0, addr: 16'hFFFF, wdata: 16'h1111, waits: 1, mrdata: 16'h0000, exp_rdata: 16'h0000};
    vecs[3] = '{we: 1'b0, addr: 16'h0000, wdata: 16'h2222, waits: 2, mrdata: 16'hFFFF, exp_rdata: 16'hFFFF};
    vecs[4] = '{we: 1'b1, addr: 16'hFFFF, wdata: 16'hFFFF, waits: 0, mrdata: 16'h3333, exp_rdata: 16'hFFFF};

    rst_n = 1'b0; enmem = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_wdata = '0;
    mack = 1'b0; mrdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.mreq", mreq, 0);
    check("rst.mwe", mwe, 0);
    check("rst.done", done, 0);
    check("rst.err", err, 0);
    check("rst.stall", stall, 0);
    check("rst.maddr", maddr, 0);
    check("rst.mwdata", mwdata, 0);
    check("rst.rdata", rdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int k = 0; k < 5; k++) begin
      run_access(vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].waits,
                 vecs[k].mrdata, vecs[k].exp_rdata, 1'b0, $sformatf("vec%0d", k));
    end
    model_rdata = 16'hFFFF;

    // Enable pulsed during REQ and during DONE must both be ignored
    model_rdata = 16'hA5C3;
    run_access(1'b0, 16'h0777, 16'h0, 2, 16'hA5C3, model_rdata, 1'b1, "reenter");

    // Async reset in the middle of an access
    enmem = 1'b1; tb_we = 1'b0; tb_addr = 16'h00AA; tb_wdata = 16'h0;
    @(posedge clk); #1;
    enmem = 1'b0;
    check("midrst.mreq_before", mreq, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst.mreq_now", mreq, 0);
    check("midrst.stall_now", stall, 0);
    done_seen = 0;
    mack = 1'b1; mrdata = 16'h9999;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    mack = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("midrst.no_done", done_seen, 0);
    check("midrst.rdata_cleared", rdata, 0);
    model_rdata = 16'h4321;
    run_access(1'b0, 16'h0ABC, 16'h0, 1, 16'h4321, model_rdata, 1'b0, "after_rst");

    // Random accesses against the transaction model
    for (int n = 0; n < 24; n++) begin
      logic        r_we;
      logic [15:0] r_addr, r_wdata, r_mdata;
      int          r_waits;
      r_we    = 1'($urandom_range(0, 1));
      r_addr  = 16'($urandom);
      r_wdata = 16'($urandom);
      r_mdata = 16'($urandom);
      r_waits = $urandom_range(0, 5);
      if (!r_we && !timed_out(r_waits)) model_rdata = r_mdata;
      run_access(r_we, r_addr, r_wdata, r_waits, r_mdata, model_rdata, 1'($urandom_range(0, 1)),
                 $sformatf("rand%0d", n));
    end

`ifdef MEM_STAGE_TIMEOUT_EN
    // No ack at all: abort after TO REQ cycles, rdata untouched
    run_access(1'b0, 16'h0C0C, 16'h0, -1, 16'h1111, model_rdata, 1'b0, "timeout_noack");
    // Ack on the limit cycle: normal completion with data
    model_rdata = 16'h2222;
    run_access(1'b0, 16'h0D0D, 16'h0, TO - 1, 16'h2222, model_rdata, 1'b0, "timeout_edge");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_mem_stage_unit
`default_nettype wire

// File: doc/mem_stage_unit.md
# mem_stage_unit

Memory-stage responder for the 16-bit RISC core. It consumes the one-hot memory-stage enable pulse from the stage sequencer and performs one load or store per pulse over a req/ack handshake to external data memory. It returns completion (`O_done`), a stall indication and load data to the datapath. It is the answering end of the sequencer's memory enable: the sequencer initiates, and this block executes the access and reports back.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- TIMEOUT_CYC, 15, maximum cycles in REQ before abort (used only with the timeout feature)

Ports:
- I_clk  in  1  clock, rising edge
- I_reset_n  in  1  asynchronous active-low reset
- I_enmem  in  1  memory-stage enable, one-cycle pulse from the sequencer
- I_we  in  1  1 = store, 0 = load; sampled with I_enmem
- I_addr  in  ADDR_W  access address; sampled with I_enmem
- I_wdata  in  DATA_W  store data; sampled with I_enmem
- O_stall  out  1  access outstanding; sequencer must hold its state
- O_done  out  1  one-cycle completion pulse
- O_err  out  1  one-cycle pulse coincident with O_done on aborted access
- O_rdata  out  DATA_W  last successfully loaded data
- O_mreq  out  1  memory request
- O_mwe  out  1  memory write enable
- O_maddr  out  ADDR_W  memory address
- O_mwdata  out  DATA_W  memory write data
- I_mack  in  1  memory acknowledge, single-cycle
- I_mrdata  in  DATA_W  memory read data; valid when I_mack=1

## Operation
- FSM states (one-hot, 3 bits): IDLE=001, REQ=010, DONE=100.
- IDLE:
  - I_enmem=1: capture I_we/I_addr/I_wdata into registers and go to REQ.
  - I_mack is ignored.
- REQ:
  - O_mreq=1. O_mwe/O_maddr/O_mwdata are driven from the captured registers and stay stable until ack.
  - I_mack=1: for a load, latch I_mrdata into O_rdata. Go to DONE.
- DONE: O_done=1 for one cycle, then go to IDLE unconditionally.
- O_stall = (state==REQ), combinational from state.
- I_enmem while not in IDLE is ignored. There is no queueing, and the access in flight is unaffected.
- O_rdata changes only on an acknowledged load. Stores and aborts leave it unchanged.
- O_maddr/O_mwdata/O_mwe hold their captured values after completion. O_mreq alone qualifies them.

## Timing
- Reset (async assert, sync release): state=IDLE; O_mreq, O_mwe, O_done, O_err, O_stall = 0; O_maddr, O_mwdata, O_rdata = 0.
- Reset mid-access: O_mreq drops immediately and the transaction is abandoned with no O_done.
- Pulse at edge 0 (I_enmem=1) puts the block in REQ from edge 0; O_mreq is high in cycle 1.
- Ack sampled at edge k puts the block in DONE after edge k; O_done is high in cycle k+1.
- Zero-wait memory (I_mack high in first REQ cycle): O_done two cycles after I_enmem; O_stall high exactly one cycle.
- Back-to-back: the earliest accepted next I_enmem is in the cycle after DONE.

## Configuration
- MEM_STAGE_TIMEOUT_EN defined:
  - A counter clears on REQ entry and increments each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYC, O_mreq drops and the block goes to DONE with O_err=1 alongside O_done.
  - Ack in the same cycle as the limit wins: normal completion, no error.
- MEM_STAGE_TIMEOUT_EN undefined:
  - REQ waits indefinitely.
  - O_err is tied to 0, and no counter logic is generated.

## Structure
- Package mem_stage_pkg:
  - one-hot state encodings IDLE/REQ/DONE
  - default ADDR_W/DATA_W
  - TIMEOUT_CYC default
- Sub-module mem_timeout_ctr:
  - clear/enable/limit-reached counter
  - instantiated only under MEM_STAGE_TIMEOUT_EN

## Test plan
- Load, ack in first REQ cycle, I_mrdata=16'hBEEF, I_addr=16'h0040 -> O_maddr=16'h0040 with O_mwe=0; O_done two cycles after I_enmem; O_rdata=16'hBEEF.
- Store I_addr=16'h1234, I_wdata=16'h5A5A, ack after 3 wait cycles -> O_mwe=1 and stable address/data throughout REQ; O_stall high 4 cycles; O_rdata unchanged.
- I_enmem pulsed again during REQ -> ignored; exactly one O_done; captured address unchanged.
- Async reset asserted in REQ -> O_mreq=0 immediately; no O_done; next access after release completes normally.
- MEM_STAGE_TIMEOUT_EN, TIMEOUT_CYC=4, no ack -> O_mreq drops after 4 REQ cycles; O_done=O_err=1 for one cycle; O_rdata unchanged.
- MEM_STAGE_TIMEOUT_EN, ack exactly on the limit cycle -> normal completion with O_err=0 and data latched.
